// File: rtl/rop_dst_fetch.sv
// Destination-fetch stage: reads the framebuffer pixel for each fragment, realigns it with the
// fragment's source colors for the blender, and blocks same-pixel hazards until writeback.
module rop_dst_fetch #(
  parameter int AW     = 20,
  parameter int RD_LAT = 3,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frag_valid,
  output logic                       frag_ready,
  input  logic [AW-1:0]              frag_addr,
  input  logic [31:0]                frag_src0,
  input  logic [31:0]                frag_src1,
  output logic                       mem_rd_en,
  output logic [AW-1:0]              mem_rd_addr,
  input  logic [31:0]                mem_rd_data,
  output logic                       blend_valid,
  output logic [31:0]                blend_src0,
  output logic [31:0]                blend_src1,
  output logic [31:0]                blend_dst,
  input  logic                       wb_valid,
  input  logic [AW-1:0]              wb_addr,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic                       wb_err,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
  state_e state_q, state_d;

  logic [AW-1:0]    sb_addr_q [DEPTH];
  logic [DEPTH-1:0] sb_vld_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [OW-1:0]    occ_q;
  logic             wb_err_q;

  logic             rd_en_q;
  logic [AW-1:0]    rd_addr_q;
  logic [31:0]      iss_s0_q, iss_s1_q;

  logic [RD_LAT-1:0] dl_v_q;
  logic [31:0]       dl_s0_q [RD_LAT];
  logic [31:0]       dl_s1_q [RD_LAT];

  logic              blend_valid_q;
  logic [31:0]       blend_s0_q, blend_s1_q, blend_dst_q;

  logic hazard, accept, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // A popping entry still counts as a hazard: no bypass from writeback.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sb_vld_q[i] && (sb_addr_q[i] == frag_addr)) hazard = 1'b1;
    end
  end

  assign frag_ready = !rst && (state_q == RUN) && (occ_q < OW'(DEPTH)) && !hazard;
  assign accept     = frag_valid && frag_ready;
  assign pop        = wb_valid && (occ_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_vld_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      wb_err_q <= 1'b0;
    end else begin
      if (accept) begin
        sb_vld_q[tail_q] <= 1'b1;
        tail_q           <= ptr_inc(tail_q);
      end
      if (pop) begin
        sb_vld_q[head_q] <= 1'b0;
        head_q           <= ptr_inc(head_q);
      end
      case ({accept, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (wb_valid && ((occ_q == '0) || (wb_addr != sb_addr_q[head_q]))) wb_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) sb_addr_q[tail_q] <= frag_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      iss_s0_q  <= '0;
      iss_s1_q  <= '0;
    end else begin
      rd_en_q <= accept;
      if (accept) begin
        rd_addr_q <= frag_addr;
        iss_s0_q  <= frag_src0;
        iss_s1_q  <= frag_src1;
      end
    end
  end

  // Source colors ride alongside the outstanding read so they meet the data on return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_v_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        dl_s0_q[i] <= '0;
        dl_s1_q[i] <= '0;
      end
    end else begin
      dl_v_q[0]  <= rd_en_q;
      dl_s0_q[0] <= iss_s0_q;
      dl_s1_q[0] <= iss_s1_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        dl_v_q[i]  <= dl_v_q[i-1];
        dl_s0_q[i] <= dl_s0_q[i-1];
        dl_s1_q[i] <= dl_s1_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blend_valid_q <= 1'b0;
      blend_s0_q    <= '0;
      blend_s1_q    <= '0;
      blend_dst_q   <= '0;
    end else begin
      blend_valid_q <= dl_v_q[RD_LAT-1];
      if (dl_v_q[RD_LAT-1]) begin
        blend_s0_q  <= dl_s0_q[RD_LAT-1];
        blend_s1_q  <= dl_s1_q[RD_LAT-1];
        blend_dst_q <= mem_rd_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      RUN:   if (flush_req) state_d = DRAIN;
      DRAIN: begin
        if (!flush_req)        state_d = RUN;
        else if (occ_q == '0)  state_d = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        if (!flush_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign blend_valid = blend_valid_q;
  assign blend_src0  = blend_s0_q;
  assign blend_src1  = blend_s1_q;
  assign blend_dst   = blend_dst_q;
  assign wb_err      = wb_err_q;
  assign occupancy   = occ_q;

endmodule
